// File: rtl/l1_thresh_pkg.sv
// Shared types and constants for the L1 beam-threshold load sequencer.
//   seq_state_t  : sequencer state (IDLE / LOAD / UPDATE)
//   THRESH_W_DEF : default threshold width
//   THRESH_RESET : reset value of a shadow threshold (all-ones = quietest)
package l1_thresh_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UPDATE = 2'd2
  } seq_state_t;

  localparam int THRESH_W_DEF = 18;

  localparam logic [THRESH_W_DEF-1:0] THRESH_RESET = {THRESH_W_DEF{1'b1}};

endpackage

// File: rtl/lowest_bit_sel.sv
// Lowest-set-bit selector, purely combinational.
//   vec_i    : candidate bit vector
//   onehot_o : one-hot of the lowest set bit of vec_i (zero when vec_i is zero)
//   idx_o    : index of that bit (zero when vec_i is zero)
//   found_o  : vec_i has at least one bit set
module lowest_bit_sel #(
  parameter int W     = 2,
  parameter int IDX_W = 1
) (
  input  logic [W-1:0]     vec_i,
  output logic [W-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan upward; the first set bit wins and masks every higher one.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    onehot_o = {W{1'b0}};
    idx_o    = {IDX_W{1'b0}};
    for (int i = 0; i < W; i++) begin
      onehot_o[i] = vec_i[i] & ~seen;
      idx_o       = (vec_i[i] && !seen) ? IDX_W'(i) : idx_o;
      seen        = seen | vec_i[i];
    end
  end

  assign found_o = |vec_i;

endmodule

// File: rtl/l1_thresh_sequencer.sv
// Owns the beam-threshold load port of the L1 beamform trigger.
// Writes land in a per-beam shadow file and mark the beam dirty; a commit
// streams every dirty beam (ascending order, one per cycle) into the trigger
// and finishes with a single update strobe.
//   aclk / aresetn      : clock, asynchronous active-low reset
//   wr_valid_i/ready_o  : shadow write handshake (ready only while idle)
//   wr_beam_i/thresh_i  : write target beam and value
//   commit_i            : single-cycle commit request
//   err_clr_i           : clears the sticky out-of-range write error
//   busy_o              : load sequence in progress
//   dirty_o             : shadow entries not yet loaded into the trigger
//   err_o               : sticky, an out-of-range write was accepted
//   thresh_o/thresh_ce_o: threshold value and one-hot beam load enable
//   update_o            : one-cycle update strobe after the last load
module l1_thresh_sequencer
  import l1_thresh_pkg::*;
#(
  parameter int NBEAMS     = 2,
  parameter int THRESH_W   = THRESH_W_DEF,
  parameter int BEAM_IDX_W = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [BEAM_IDX_W-1:0] wr_beam_i,
  input  logic [THRESH_W-1:0]   wr_thresh_i,
  input  logic                  commit_i,
  input  logic                  err_clr_i,
  output logic                  busy_o,
  output logic [NBEAMS-1:0]     dirty_o,
  output logic                  err_o,
  output logic [THRESH_W-1:0]   thresh_o,
  output logic [NBEAMS-1:0]     thresh_ce_o,
  output logic                  update_o
);

  seq_state_t            state_q, state_d;
  logic [NBEAMS-1:0]     pend_q, pend_d;
  logic [NBEAMS-1:0]     dirty_q, dirty_d;
  logic [NBEAMS-1:0]     thresh_ce_q, thresh_ce_d;
  logic [THRESH_W-1:0]   thresh_q, thresh_d;
  logic                  commit_pend_q, commit_pend_d;
  logic                  err_q, err_d;
  logic                  update_q, update_d;
  logic                  busy_q, busy_d;
  logic [THRESH_W-1:0]   shadow_q [NBEAMS];
  logic [THRESH_W-1:0]   shadow_d [NBEAMS];

  logic                  wr_fire_s;
  logic                  wr_in_range_s;
  logic                  wr_err_s;
  logic                  commit_req_s;
  logic [NBEAMS-1:0]     wr_bit_s;
  logic [NBEAMS-1:0]     commit_mask_s;
  logic [NBEAMS-1:0]     sel_vec_s;
  logic [NBEAMS-1:0]     sel_onehot_s;
  logic [BEAM_IDX_W-1:0] sel_idx_s;
  logic                  sel_found_s;

  // Ready is the one combinational output: accept writes only while idle.
  assign wr_ready_o = (state_q == IDLE);
  assign wr_fire_s  = wr_valid_i && (state_q == IDLE);

  // One-hot of the accepted write's beam; stays zero for out-of-range beams,
  // which is how an out-of-range write is recognised.
  always_comb begin
    wr_bit_s = {NBEAMS{1'b0}};
    for (int i = 0; i < NBEAMS; i++) begin
      wr_bit_s[i] = wr_fire_s && (wr_beam_i == BEAM_IDX_W'(i));
    end
  end

  assign wr_in_range_s = |wr_bit_s;
  assign wr_err_s      = wr_fire_s && !wr_in_range_s;
  assign commit_req_s  = commit_i || commit_pend_q;
  // A write accepted in the commit cycle is part of that commit.
  assign commit_mask_s = dirty_q | wr_bit_s;
  // Idle picks the first beam of the new mask; LOAD walks what is left.
  assign sel_vec_s     = (state_q == IDLE) ? commit_mask_s : pend_q;

  lowest_bit_sel #(
    .W     (NBEAMS),
    .IDX_W (BEAM_IDX_W)
  ) u_sel (
    .vec_i    (sel_vec_s),
    .onehot_o (sel_onehot_s),
    .idx_o    (sel_idx_s),
    .found_o  (sel_found_s)
  );

  // Next-state logic for the sequencer, shadow file and all registered outputs.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    dirty_d       = dirty_q;
    commit_pend_d = commit_pend_q;
    thresh_d      = thresh_q;
    thresh_ce_d   = {NBEAMS{1'b0}};
    update_d      = 1'b0;
    shadow_d      = shadow_q;

    for (int i = 0; i < NBEAMS; i++) begin
      shadow_d[i] = wr_bit_s[i] ? wr_thresh_i : shadow_q[i];
    end
    dirty_d = dirty_q | wr_bit_s;

    // A new error beats a simultaneous clear.
    if (wr_err_s) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      IDLE: begin
        // The pending commit is consumed here whether or not it starts a load.
        commit_pend_d = 1'b0;
        if (commit_req_s && sel_found_s) begin
          // The first beam is issued on the commit edge so its enable
          // appears in the very next cycle. shadow_d carries a same-cycle write.
          thresh_ce_d = sel_onehot_s;
          thresh_d    = shadow_d[sel_idx_s];
          dirty_d     = dirty_d & ~sel_onehot_s;
          pend_d      = commit_mask_s & ~sel_onehot_s;
          state_d     = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        commit_pend_d = commit_pend_q | commit_i;
        if (sel_found_s) begin
          thresh_ce_d = sel_onehot_s;
          thresh_d    = shadow_q[sel_idx_s];
          dirty_d     = dirty_d & ~sel_onehot_s;
          pend_d      = pend_q & ~sel_onehot_s;
          state_d     = LOAD;
        end else begin
          update_d = 1'b1;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        commit_pend_d = commit_pend_q | commit_i;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, shadow file and output registers; reset leaves every beam dirty.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      pend_q        <= {NBEAMS{1'b0}};
      dirty_q       <= {NBEAMS{1'b1}};
      commit_pend_q <= 1'b0;
      err_q         <= 1'b0;
      thresh_q      <= {THRESH_W{1'b0}};
      thresh_ce_q   <= {NBEAMS{1'b0}};
      update_q      <= 1'b0;
      busy_q        <= 1'b0;
      for (int i = 0; i < NBEAMS; i++) begin
        shadow_q[i] <= {THRESH_W{1'b1}};
      end
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      dirty_q       <= dirty_d;
      commit_pend_q <= commit_pend_d;
      err_q         <= err_d;
      thresh_q      <= thresh_d;
      thresh_ce_q   <= thresh_ce_d;
      update_q      <= update_d;
      busy_q        <= busy_d;
      shadow_q      <= shadow_d;
    end
  end

  assign busy_o      = busy_q;
  assign dirty_o     = dirty_q;
  assign err_o       = err_q;
  assign thresh_o    = thresh_q;
  assign thresh_ce_o = thresh_ce_q;
  assign update_o    = update_q;

endmodule

// File: tb/tb_l1_thresh_sequencer.sv
// Bench for l1_thresh_sequencer with NBEAMS=3 so that an out-of-range beam
// index (3) is representable. Directed steps follow the intended behaviour,
// then randomized traffic runs against a transaction-level reference model.
module tb_l1_thresh_sequencer;

  localparam int NB = 3;
  localparam int TW = 18;
  localparam int IW = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [IW-1:0] wr_beam_i = '0;
  logic [TW-1:0] wr_thresh_i = '0;
  logic          commit_i = 1'b0;
  logic          err_clr_i = 1'b0;
  logic          busy_o;
  logic [NB-1:0] dirty_o;
  logic          err_o;
  logic [TW-1:0] thresh_o;
  logic [NB-1:0] thresh_ce_o;
  logic          update_o;

  always #5 aclk = ~aclk;

  l1_thresh_sequencer #(.NBEAMS(NB), .THRESH_W(TW), .BEAM_IDX_W(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_beam_i(wr_beam_i), .wr_thresh_i(wr_thresh_i),
    .commit_i(commit_i), .err_clr_i(err_clr_i),
    .busy_o(busy_o), .dirty_o(dirty_o), .err_o(err_o),
    .thresh_o(thresh_o), .thresh_ce_o(thresh_ce_o), .update_o(update_o)
  );

  // Reference model: one entry per busy cycle the trigger should observe.
  typedef struct packed {
    logic [NB-1:0] ce;
    logic [TW-1:0] th;
    logic          upd;
    logic [NB-1:0] dirty;
  } ent_t;

  ent_t          sched[$];
  ent_t          cur;
  bit            cur_v;
  logic [TW-1:0] m_sh [NB];
  logic [NB-1:0] m_dirty;
  bit            m_err;
  bit            m_cpend;
  logic [TW-1:0] m_th;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_sh[b] = {TW{1'b1}};
    m_dirty = {NB{1'b1}};
    m_err   = 1'b0;
    m_cpend = 1'b0;
    m_th    = '0;
    sched.delete();
    cur_v   = 1'b0;
    cur     = '0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".thresh"}, 32'(thresh_o),    32'(m_th));
    chk({tag, ".ce"},     32'(thresh_ce_o), cur_v ? 32'(cur.ce) : 32'd0);
    chk({tag, ".upd"},    32'(update_o),    cur_v ? 32'(cur.upd) : 32'd0);
    chk({tag, ".busy"},   32'(busy_o),      32'(cur_v));
    chk({tag, ".dirty"},  32'(dirty_o),     cur_v ? 32'(cur.dirty) : 32'(m_dirty));
    chk({tag, ".err"},    32'(err_o),       32'(m_err));
  endtask

  // One clock: drive inputs, predict the edge, then compare after it.
  task automatic step(input string tag, input bit wv, input int wb,
                      input logic [TW-1:0] wt, input bit cm, input bit ec);
    bit            idle;
    bit            nerr;
    logic [NB-1:0] d;
    ent_t          e;
    wr_valid_i  = wv;
    wr_beam_i   = IW'(wb);
    wr_thresh_i = wt;
    commit_i    = cm;
    err_clr_i   = ec;
    idle = !cur_v;
    #1;
    chk({tag, ".ready"}, 32'(wr_ready_o), 32'(idle));
    nerr = 1'b0;
    if (wv && idle) begin
      if (wb < NB) begin
        m_sh[wb]    = wt;
        m_dirty[wb] = 1'b1;
      end else begin
        nerr = 1'b1;
      end
    end
    if (nerr) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    if (!idle) begin
      if (cm) m_cpend = 1'b1;
    end else begin
      if ((cm || m_cpend) && m_dirty != '0) begin
        d = m_dirty;
        for (int b = 0; b < NB; b++) begin
          if (d[b]) begin
            d[b]    = 1'b0;
            e.ce    = '0;
            e.ce[b] = 1'b1;
            e.th    = m_sh[b];
            e.upd   = 1'b0;
            e.dirty = d;
            sched.push_back(e);
          end
        end
        e = '0;
        e.upd   = 1'b1;
        e.dirty = d;
        sched.push_back(e);
        m_dirty = d;
      end
      m_cpend = 1'b0;
    end
    if (sched.size() != 0) begin
      cur   = sched.pop_front();
      cur_v = 1'b1;
      if (cur.ce != '0) m_th = cur.th;
    end else begin
      cur_v = 1'b0;
    end
    @(posedge aclk);
    #1;
    chk_outs(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  // Pull reset in the middle of a cycle; outputs must clear without a clock.
  task automatic async_reset_mid(input string tag);
    #2;
    aresetn = 1'b0;
    #1;
    model_reset();
    chk_outs({tag, ".async"});
    chk({tag, ".ready"}, 32'(wr_ready_o), 32'd1);
    wr_valid_i = 1'b0;
    commit_i   = 1'b0;
    err_clr_i  = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk_outs({tag, ".rel"});
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    chk_outs("rst");
    chk("rst.ready", 32'(wr_ready_o), 32'd1);
    chk("rst.dirty_ones", 32'(dirty_o), 32'h7);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk_outs("rst_rel");

    // Commit with no writes: every beam loads its all-ones reset value.
    step("tp1.commit", 1'b0, 0, '0, 1'b1, 1'b0);
    chk("tp1.c1.ce", 32'(thresh_ce_o), 32'h1);
    chk("tp1.c1.th", 32'(thresh_o), 32'h3FFFF);
    chk("tp1.c1.dirty", 32'(dirty_o), 32'h6);
    idle_step("tp1.c2");
    chk("tp1.c2.ce", 32'(thresh_ce_o), 32'h2);
    idle_step("tp1.c3");
    chk("tp1.c3.dirty", 32'(dirty_o), 32'h0);
    idle_step("tp1.c4");
    chk("tp1.c4.upd", 32'(update_o), 32'h1);
    idle_step("tp1.c5");

    // Single dirty beam: k=1, update in cycle 2, ready in cycle 3.
    step("tp2.wr", 1'b1, 1, 18'h00123, 1'b0, 1'b0);
    step("tp2.commit", 1'b0, 0, '0, 1'b1, 1'b0);
    chk("tp2.c1.ce", 32'(thresh_ce_o), 32'h2);
    chk("tp2.c1.th", 32'(thresh_o), 32'h00123);
    idle_step("tp2.c2");
    chk("tp2.c2.upd", 32'(update_o), 32'h1);
    idle_step("tp2.c3");

    // Write and commit in the same cycle on a clean mask.
    step("tp3.wrcommit", 1'b1, 0, 18'h00400, 1'b1, 1'b0);
    chk("tp3.c1.th", 32'(thresh_o), 32'h00400);
    idle_step("tp3.c2");
    idle_step("tp3.c3");

    // Commits while busy collapse; stalled writes are not taken.
    step("tp4.wr", 1'b1, 2, 18'h00007, 1'b0, 1'b0);
    step("tp4.commit", 1'b1, 0, 18'h00005, 1'b1, 1'b0);
    step("tp4.busy1", 1'b1, 1, 18'h00009, 1'b1, 1'b0);
    step("tp4.busy2", 1'b1, 1, 18'h00009, 1'b1, 1'b0);
    idle_step("tp4.pend_nothing");
    idle_step("tp4.quiet1");
    chk("tp4.noupd", 32'(update_o), 32'h0);
    // Pending commit plus a write in the one-cycle idle gap.
    step("tp4b.commit", 1'b1, 1, 18'h00011, 1'b1, 1'b0);
    step("tp4b.busy", 1'b0, 0, '0, 1'b1, 1'b0);
    idle_step("tp4b.upd");
    step("tp4b.gapwr", 1'b1, 0, 18'h00005, 1'b0, 1'b0);
    chk("tp4b.gap.ce", 32'(thresh_ce_o), 32'h1);
    idle_step("tp4b.upd2");
    idle_step("tp4b.done");

    // Out-of-range write and error clear, then clear racing a new error.
    step("tp5.badwr", 1'b1, 3, 18'h3ABCD, 1'b0, 1'b0);
    chk("tp5.err", 32'(err_o), 32'h1);
    step("tp5.clr", 1'b0, 0, '0, 1'b0, 1'b1);
    step("tp6.race", 1'b1, 3, 18'h00001, 1'b0, 1'b1);
    chk("tp6.err", 32'(err_o), 32'h1);
    step("tp6.clr", 1'b0, 0, '0, 1'b0, 1'b1);

    // Reset during cycle 1 of a 2-beam load.
    step("tp7.wr0", 1'b1, 0, 18'h00AAA, 1'b0, 1'b0);
    step("tp7.wr2", 1'b1, 2, 18'h00BBB, 1'b0, 1'b0);
    step("tp7.commit", 1'b0, 0, '0, 1'b1, 1'b0);
    async_reset_mid("tp7");
    chk("tp7.dirty_all", 32'(dirty_o), 32'h7);
    idle_step("tp7.after");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i == 150 || i == 300) async_reset_mid("rnd.rst");
      step("rnd", ($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
           TW'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end
    repeat (6) idle_step("drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
